// File: rtl/tt_alu_pkg.sv
// Shared opcode encoding and status-flag bit positions for the accumulator ALU tile.
// Optional build macro ALU_SAT_EN (used in alu_core) selects saturating ADD/SUB.
package tt_alu_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_SHR  = 3'b111
  } op_e;

  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_C = 5;
  localparam int FLAG_V = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational 8-bit ALU datapath: result, carry/borrow and signed overflow.
// Build macro ALU_SAT_EN: ADD clamps to 8'hFF on carry, SUB clamps to 8'h00 on borrow.
module alu_core
  import tt_alu_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] b,
  input  op_e        opcode,
  output logic [7:0] result,
  output logic       carry,
  output logic       overflow
);

  logic [8:0]  sum;
  logic [8:0]  diff;
  logic [15:0] shl_wide;
  logic [15:0] shr_wide;

  assign sum  = {1'b0, acc} + {1'b0, b};
  assign diff = {1'b0, acc} - {1'b0, b};
  // A guard byte catches the last bit shifted out; a zero shift leaves it 0.
  assign shl_wide = {8'h00, acc} << b[2:0];
  assign shr_wide = {acc, 8'h00} >> b[2:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    result   = acc;
    carry    = 1'b0;
    overflow = 1'b0;
    unique case (opcode)
      OP_LOAD: result = b;
      OP_ADD: begin
        carry    = sum[8];
        overflow = (acc[7] == b[7]) && (sum[7] != acc[7]);
`ifdef ALU_SAT_EN
        result   = sum[8] ? 8'hFF : sum[7:0];
`else
        result   = sum[7:0];
`endif
      end
      OP_SUB: begin
        carry    = diff[8];
        overflow = (acc[7] != b[7]) && (diff[7] != acc[7]);
`ifdef ALU_SAT_EN
        result   = diff[8] ? 8'h00 : diff[7:0];
`else
        result   = diff[7:0];
`endif
      end
      OP_AND: result = acc & b;
      OP_OR:  result = acc | b;
      OP_XOR: result = acc ^ b;
      OP_SHL: begin
        result = shl_wide[7:0];
        carry  = shl_wide[8];
      end
      OP_SHR: begin
        result = shr_wide[15:8];
        carry  = shr_wide[7];
      end
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/tt_um_trinhgiahuy.sv
// TinyTapeout accumulator ALU tile: ACC/C/V registers, strobe gating and pin mapping.
// Build macro ALU_SAT_EN (see alu_core) enables saturating ADD/SUB.
module tt_um_trinhgiahuy
  import tt_alu_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [7:0] acc;
  logic       c_flag;
  logic       v_flag;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_overflow;
  logic       execute;
  logic       unused_uio_hi;

  assign execute       = ena && uio_in[3];
  assign unused_uio_hi = &{1'b0, uio_in[7:4]};

  alu_core u_alu_core (
    .acc      (acc),
    .b        (ui_in),
    .opcode   (op_e'(uio_in[2:0])),
    .result   (alu_result),
    .carry    (alu_carry),
    .overflow (alu_overflow)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= 8'h00;
      c_flag <= 1'b0;
      v_flag <= 1'b0;
    end else if (execute) begin
      acc    <= alu_result;
      c_flag <= alu_carry;
      v_flag <= alu_overflow;
    end
  end

  always_comb begin
    uio_out         = 8'h00;
    uio_out[FLAG_Z] = (acc == 8'h00);
    uio_out[FLAG_N] = acc[7];
    uio_out[FLAG_C] = c_flag;
    uio_out[FLAG_V] = v_flag;
  end

  assign uo_out = acc;
  assign uio_oe = 8'hF0;

endmodule

// File: tb/tb_tt_um_trinhgiahuy.sv
// Scoreboard bench for tt_um_trinhgiahuy: stimulus pushes expected pins, a monitor pops and compares.
module tb_tt_um_trinhgiahuy;

  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       ena;
  logic       clk;
  logic       rst_n;

  tt_um_trinhgiahuy dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] uo;
    logic [7:0] uio;
    logic [7:0] oe;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  // Reference model state, plain integers.
  int m_acc = 0;
  int m_c   = 0;
  int m_v   = 0;

  function automatic int to_signed8(int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_exec(input int op, input int b);
    int s;
    int n;
    n = b % 8;
    case (op)
      0: begin m_acc = b; m_c = 0; m_v = 0; end
      1: begin
        s   = m_acc + b;
        m_c = (s > 255) ? 1 : 0;
        s   = to_signed8(m_acc) + to_signed8(b);
        m_v = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_SAT_EN
        m_acc = m_c ? 255 : (m_acc + b) % 256;
`else
        m_acc = (m_acc + b) % 256;
`endif
      end
      2: begin
        m_c = (m_acc < b) ? 1 : 0;
        s   = to_signed8(m_acc) - to_signed8(b);
        m_v = (s > 127 || s < -128) ? 1 : 0;
`ifdef ALU_SAT_EN
        m_acc = m_c ? 0 : m_acc - b;
`else
        m_acc = (m_acc - b + 256) % 256;
`endif
      end
      3: begin m_acc = m_acc & b; m_c = 0; m_v = 0; end
      4: begin m_acc = m_acc | b; m_c = 0; m_v = 0; end
      5: begin m_acc = m_acc ^ b; m_c = 0; m_v = 0; end
      6: begin
        m_c   = (n == 0) ? 0 : (m_acc >> (8 - n)) % 2;
        m_acc = (m_acc * (1 << n)) % 256;
        m_v   = 0;
      end
      default: begin
        m_c   = (n == 0) ? 0 : (m_acc >> (n - 1)) % 2;
        m_acc = m_acc >> n;
        m_v   = 0;
      end
    endcase
  endtask

  task automatic apply(input logic r, input logic e, input logic s,
                       input int op, input int b, input string name);
    exp_t ex;
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = 8'(b);
    uio_in = {4'($urandom_range(0, 15)), s, 3'(op)};
    if (!r) begin
      m_acc = 0; m_c = 0; m_v = 0;
    end else if (e && s) begin
      model_exec(op, b);
    end
    ex.uo  = 8'(m_acc);
    ex.uio = {(m_acc == 0) ? 1'b1 : 1'b0, (m_acc >= 128) ? 1'b1 : 1'b0,
              1'(m_c), 1'(m_v), 4'h0};
    ex.oe  = 8'hF0;
    exp_q.push_back(ex);
    name_q.push_back(name);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    exp_t  ex;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        nm = name_q.pop_front();
        tests_run++;
        if (uo_out !== ex.uo || uio_out !== ex.uio || uio_oe !== ex.oe) begin
          tests_failed++;
          $display("FAIL %s: got uo_out=%h uio_out=%h uio_oe=%h, expected %h %h %h",
                   nm, uo_out, uio_out, uio_oe, ex.uo, ex.uio, ex.oe);
        end
      end
    end
  end

  initial begin
    int op;
    int b;
    int pick;
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

    apply(0, 1, 1, 0, 8'h55, "reset_1");
    apply(0, 0, 0, 0, 8'h00, "reset_2");

    apply(1, 1, 1, 0, 8'h7F, "load_7f");
    apply(1, 1, 1, 1, 8'h01, "add_overflow");
    apply(1, 1, 1, 0, 8'hFF, "load_ff");
    apply(1, 1, 1, 1, 8'h01, "add_carry");
    apply(1, 1, 1, 0, 8'h05, "load_05");
    apply(1, 1, 1, 2, 8'h06, "sub_borrow");
    apply(1, 1, 1, 0, 8'h81, "load_81");
    apply(1, 1, 1, 6, 8'h01, "shl_1");
    apply(1, 1, 1, 7, 8'h02, "shr_2");
    apply(1, 1, 1, 7, 8'h00, "shr_0");
    apply(1, 1, 1, 0, 8'hA5, "load_a5");
    apply(1, 0, 1, 0, 8'h11, "hold_ena0");
    apply(1, 1, 0, 1, 8'h22, "hold_strobe0");
    apply(1, 1, 1, 1, 8'h01, "strobe_n1");
    apply(1, 1, 1, 1, 8'h01, "strobe_n2");
    apply(0, 1, 1, 0, 8'h3C, "load_during_reset");
    apply(1, 1, 1, 4, 8'h3C, "resume_or");

    for (int i = 0; i < 600; i++) begin
      op   = int'($urandom_range(0, 7));
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: b = 8'h00;
        1: b = 8'hFF;
        2: b = 8'h7F;
        3: b = 8'h80;
        default: b = int'($urandom_range(0, 255));
      endcase
      apply(($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1,
            op, b, "random");
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tt_um_trinhgiahuy.md
TT_UM_TRINHGIAHUY -- requirements
Module: tt_um_trinhgiahuy

Interface
REQ-001 The block SHALL have no parameters; all data widths are fixed at 8 bits (TinyTapeout tile pinout).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  tile enable; when low, all state holds.
REQ-005 ui_in  input  8  operand B, or shift amount in ui_in[2:0] for shift ops.
REQ-006 uio_in  input  8  [2:0] opcode, [3] execute strobe, [7:4] ignored.
REQ-007 uo_out  output  8  accumulator ACC.
REQ-008 uio_out  output  8  [7] Z, [6] N, [5] C, [4] V; [3:0] driven 0.
REQ-009 uio_oe  output  8  constant 8'hF0 at all times, including during reset.

Function
REQ-010 An op SHALL execute on a rising clk edge when rst_n=1, ena=1 and uio_in[3]=1 (level-sampled; a strobe held high for N cycles executes N times).
REQ-011 Results SHALL be registered: ACC and flags change on the executing edge and are visible immediately after it (1-cycle latency); there are no combinational paths from inputs to outputs.
REQ-012 Opcodes: 000 LOAD ACC=B; 001 ADD ACC=ACC+B; 010 SUB ACC=ACC-B; 011 AND; 100 OR; 101 XOR; 110 SHL ACC<<ui_in[2:0]; 111 SHR (logical) ACC>>ui_in[2:0].
REQ-013 All arithmetic SHALL be modulo 256 (wrap-around), unless saturation is compiled in.
REQ-014 Z=(ACC==0) and N=ACC[7] SHALL be derived combinationally from the ACC register.
REQ-015 C and V SHALL be registers updated only on executing edges.
REQ-016 ADD: C = carry out of bit 7; V = signed overflow (operands of equal sign, result of opposite sign).
REQ-017 SUB: C = borrow (1 when ACC < B unsigned); V = signed overflow of ACC-B.
REQ-018 LOAD, AND, OR and XOR SHALL clear C and V.
REQ-019 SHL/SHR: C = last bit shifted out; V=0; a shift amount of 0 leaves ACC unchanged and clears C.
REQ-020 With strobe=0 or ena=0, ACC, C and V SHALL hold.

Reset
REQ-021 On a rising clk edge with rst_n=0: ACC=0, C=0, V=0; hence uo_out=8'h00 and uio_out=8'h80 (Z=1). Reset takes priority over any strobe.
REQ-022 Asserting reset mid-sequence SHALL discard any op presented on that edge; operation resumes on the first edge with rst_n=1.

Configuration
REQ-023 Macro ALU_SAT_EN: when defined, ADD clamps to 8'hFF on carry and SUB clamps to 8'h00 on borrow. C and V are reported exactly as in the unsaturated case, with V computed on the unsaturated result.
REQ-024 When ALU_SAT_EN is undefined, ADD and SUB SHALL wrap modulo 256.

Structure
REQ-025 A shared package tt_alu_pkg SHALL hold the 3-bit opcode enum/constants and the flag bit-index constants (Z=7, N=6, C=5, V=4).
REQ-026 The combinational datapath SHALL be one sub-module, alu_core: inputs ACC, B, opcode; outputs result, carry and overflow.
REQ-027 The top level SHALL contain only the ACC/C/V registers, strobe/enable gating, reset logic and output assignments.

Verification
REQ-028 Reset: rst_n=0 for 2 clocks -> uo_out=00, uio_out=80, uio_oe=F0.
REQ-029 LOAD 8'h7F, then ADD 8'h01 -> uo_out=80, flags N=1, V=1, C=0, Z=0 (uio_out=50).
REQ-030 LOAD 8'hFF, then ADD 8'h01 -> uo_out=00, Z=1, C=1 (uio_out=A0); with ALU_SAT_EN -> uo_out=FF, C=1, N=1.
REQ-031 LOAD 8'h05, then SUB 8'h06 -> uo_out=FF, C=1, N=1; with ALU_SAT_EN -> uo_out=00, Z=1, C=1.
REQ-032 LOAD 8'h81, then SHL 1 -> uo_out=02, C=1; then SHR 2 -> uo_out=00, C=1, Z=1; then SHR 0 -> uo_out=00, C=0.
REQ-033 Hold checks: strobe=1 with ena=0 -> no change; LOAD 8'h3C with rst_n=0 on the same edge -> uo_out=00.
